// File: rtl/approx_mult_eval_pkg.sv
// Shared constants and FSM encoding for the approximate-multiplier error evaluator.
package approx_mult_eval_pkg;

    localparam int OPW      = 4;
    localparam int PW       = 8;
    localparam int N_PAIRS  = 256;
    localparam int IDX_W    = $clog2(N_PAIRS);
    localparam int ERRCNT_W = 9;
    localparam int SUM_W    = 16;
    localparam int BIAS_W   = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

endpackage

// File: rtl/err_eval_delay.sv
// MUL_LAT-deep delay line carrying the issued index and its valid bit so the
// exact product lines up with the multiplier's returned product.
module err_eval_delay
    import approx_mult_eval_pkg::*;
#(
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic             vld_out,
    output logic [IDX_W-1:0] idx_out
);

    generate
        if (MUL_LAT == 0) begin : g_pass
            logic unused_clk_rst;

            assign unused_clk_rst = clk ^ rst_n;
            assign vld_out        = vld_in;
            assign idx_out        = idx_in;
        end else begin : g_pipe
            logic             vld_q [MUL_LAT];
            logic             vld_d [MUL_LAT];
            logic [IDX_W-1:0] idx_q [MUL_LAT];
            logic [IDX_W-1:0] idx_d [MUL_LAT];

            always_comb begin
                vld_d[0] = vld_in;
                idx_d[0] = idx_in;
                for (int k = 1; k < MUL_LAT; k++) begin
                    vld_d[k] = vld_q[k-1];
                    idx_d[k] = idx_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < MUL_LAT; k++) begin
                        vld_q[k] <= 1'b0;
                    end
                end else begin
                    vld_q <= vld_d;
                end
            end

            // Index payload needs no reset; only the valid bit qualifies it.
            always_ff @(posedge clk) begin
                idx_q <= idx_d;
            end

            assign vld_out = vld_q[MUL_LAT-1];
            assign idx_out = idx_q[MUL_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/approx_mult_err_eval.sv
// Sweeps all 4x4 operand pairs through an attached approximate multiplier and
// accumulates error statistics. Define ERR_BIAS_EN to add the signed err_bias sum.
module approx_mult_err_eval
    import approx_mult_eval_pkg::*;
#(
    parameter int MUL_LAT = 0,
    parameter int OPW     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [OPW-1:0]             mul_a,
    output logic [OPW-1:0]             mul_b,
    input  logic [PW-1:0]              mul_r,
    output logic [ERRCNT_W-1:0]        err_cnt,
    output logic [SUM_W-1:0]           sum_abs_err,
    output logic [PW-1:0]              max_abs_err,
`ifdef ERR_BIAS_EN
    output logic signed [BIAS_W-1:0]   err_bias,
`endif
    output logic [OPW-1:0]             worst_a,
    output logic [OPW-1:0]             worst_b
);

    function automatic logic [PW-1:0] abs_err(input logic signed [PW:0] d);
        logic signed [PW:0] m;
        m = (d < 0) ? -d : d;
        return m[PW-1:0];
    endfunction

    eval_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       drain_q, drain_d;
    logic             clr;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            SWEEP: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_PAIRS - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(MUL_LAT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    assign busy  = (state_q == SWEEP) || (state_q == DRAIN);
    assign done  = (state_q == DONE);
    assign mul_a = idx_q[2*OPW-1:OPW];
    assign mul_b = idx_q[OPW-1:0];

    // ---- stage p0: index re-aligned to the returned product, compare ----
    logic             vld_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [PW-1:0]    exact_p0;
    logic signed [PW:0] diff_p0;

    err_eval_delay #(
        .MUL_LAT (MUL_LAT)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (state_q == SWEEP),
        .idx_in  (idx_q),
        .vld_out (vld_p0),
        .idx_out (idx_p0)
    );

    always_comb begin
        exact_p0 = PW'(idx_p0[2*OPW-1:OPW]) * PW'(idx_p0[OPW-1:0]);
        diff_p0  = $signed({1'b0, mul_r}) - $signed({1'b0, exact_p0});
    end

    // ---- stage p1: registered sample ----
    logic               vld_p1_q, vld_p1_d;
    logic [IDX_W-1:0]   idx_p1_q, idx_p1_d;
    logic signed [PW:0] diff_p1_q, diff_p1_d;

    always_comb begin
        vld_p1_d  = vld_p0;
        idx_p1_d  = idx_p0;
        diff_p1_d = diff_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1_q  <= idx_p1_d;
        diff_p1_q <= diff_p1_d;
    end

    // ---- accumulate: statistics registers ----
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [PW-1:0]       max_q, max_d;
    logic [OPW-1:0]      wa_q, wa_d;
    logic [OPW-1:0]      wb_q, wb_d;
    logic [PW-1:0]       abs_p1;

    always_comb begin
        err_cnt_d = err_cnt_q;
        sum_d     = sum_q;
        max_d     = max_q;
        wa_d      = wa_q;
        wb_d      = wb_q;
        abs_p1    = abs_err(diff_p1_q);
        if (clr) begin
            err_cnt_d = '0;
            sum_d     = '0;
            max_d     = '0;
            wa_d      = '0;
            wb_d      = '0;
        end else if (vld_p1_q) begin
            if (diff_p1_q != '0) begin
                err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
            sum_d = sum_q + SUM_W'(abs_p1);
            // Strictly greater keeps the earliest pair on ties.
            if (abs_p1 > max_q) begin
                max_d = abs_p1;
                wa_d  = idx_p1_q[2*OPW-1:OPW];
                wb_d  = idx_p1_q[OPW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            wa_q      <= '0;
            wb_q      <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            wa_q      <= wa_d;
            wb_q      <= wb_d;
        end
    end

    assign err_cnt     = err_cnt_q;
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;
    assign worst_a     = wa_q;
    assign worst_b     = wb_q;

`ifdef ERR_BIAS_EN
    logic signed [BIAS_W-1:0] bias_q, bias_d;

    always_comb begin
        bias_d = bias_q;
        if (clr) begin
            bias_d = '0;
        end else if (vld_p1_q) begin
            bias_d = bias_q + BIAS_W'(diff_p1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else begin
            bias_q <= bias_d;
        end
    end

    assign err_bias = bias_q;
`endif

endmodule
